// File: rtl/nh7020_dac_frame_writer.sv
// nh7020_dac_frame_writer
// Serialises 16-bit VCTCXO tuning words into 24-bit AD5683 SPI write frames
// {CMD, word, 4'b0000}, shifted MSB first. While a frame is in flight one
// further word may wait in a pending register; a newer word replaces it.
// All pin outputs are registered from the current state, so the pins lag the
// FSM by one cycle uniformly. This gives the 2-cycle dat_valid -> sync_n
// latency, and the pins return to idle levels the moment reset is asserted.
// Optional build macro: NH7020_DAC_SKIP_DUP_EN drops any word equal to the last
// word sent.
module nh7020_dac_frame_writer #(
    parameter int         SCLK_DIV   = 4,
    parameter int         GAP_CYCLES = 8,
    parameter logic [3:0] CMD        = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dat,
    input  logic        dat_valid,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);
    localparam int HW = $clog2(SCLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]    LAST_BIT  = 5'd23;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_reg, state_next;
    logic [HW-1:0] half_cnt_reg, half_cnt_next;
    logic [4:0]    bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          phase_reg, phase_next;     // in SHIFT: 0 = sclk low half, 1 = sclk high half
    logic [23:0]   shift_reg, shift_next;
    logic [15:0]   pending_reg, pending_next;
    logic          pending_valid_reg, pending_valid_next;

    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          sclk_reg, sclk_next;
    logic          mosi_reg, mosi_next;
    logic          sync_n_reg, sync_n_next;

    logic          take_word;
    logic          drop_word;
    logic [15:0]   word;

    // A fresh strobe always beats an older pending word
    assign word = dat_valid ? dat : pending_reg;

`ifdef NH7020_DAC_SKIP_DUP_EN
    logic [15:0] last_sent_reg;
    logic        last_valid_reg;

    assign drop_word = last_valid_reg && (word == last_sent_reg);

    // Remember the most recent word that actually went out on the wire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sent_reg  <= '0;
            last_valid_reg <= 1'b0;
        end else if (take_word && !drop_word) begin
            last_sent_reg  <= word;
            last_valid_reg <= 1'b1;
        end
    end
`else
    assign drop_word = 1'b0;
`endif

    // Next-state, counters, shifter, pending slot and next pin values
    always_comb begin
        state_next         = state_reg;
        half_cnt_next      = half_cnt_reg;
        bit_cnt_next       = bit_cnt_reg;
        gap_cnt_next       = gap_cnt_reg;
        phase_next         = phase_reg;
        shift_next         = shift_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        take_word          = 1'b0;

        // Any strobe while a frame is running lands in the pending slot
        if (dat_valid && (state_reg != IDLE)) begin
            pending_next       = dat;
            pending_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                take_word = dat_valid || pending_valid_reg;
            end
            SETUP: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    phase_next    = 1'b0;
                    bit_cnt_next  = '0;
                    state_next    = SHIFT;
                end else begin
                    half_cnt_next = half_cnt_reg + HW'(1);
                end
            end
            SHIFT: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    if (!phase_reg) begin
                        // low -> high: present the next bit with the rising edge
                        phase_next = 1'b1;
                        shift_next = {shift_reg[22:0], 1'b0};
                    end else if (bit_cnt_reg == LAST_BIT) begin
                        state_next = HOLD;
                    end else begin
                        phase_next   = 1'b0;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + HW'(1);
                end
            end
            HOLD: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    gap_cnt_next  = '0;
                    state_next    = GAP;
                end else begin
                    half_cnt_next = half_cnt_reg + HW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    take_word  = dat_valid || pending_valid_reg;
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Starting a frame consumes whichever word was chosen
        if (take_word) begin
            pending_valid_next = 1'b0;
            if (drop_word) begin
                state_next = IDLE;
            end else begin
                shift_next    = {CMD, word, 4'b0000};
                half_cnt_next = '0;
                state_next    = SETUP;
            end
        end

        busy_next   = (state_next != IDLE);
        sync_n_next = !((state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD));
        sclk_next   = !((state_reg == SHIFT) && !phase_reg);
        mosi_next   = sync_n_next ? 1'b0 : shift_reg[23];
        done_next   = (state_reg == GAP) && (gap_cnt_reg == '0);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            half_cnt_reg      <= '0;
            bit_cnt_reg       <= '0;
            gap_cnt_reg       <= '0;
            phase_reg         <= 1'b0;
            shift_reg         <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            half_cnt_reg      <= half_cnt_next;
            bit_cnt_reg       <= bit_cnt_next;
            gap_cnt_reg       <= gap_cnt_next;
            phase_reg         <= phase_next;
            shift_reg         <= shift_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
        end
    end

    // Registered pins and status; reset drives the SPI bus idle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sclk_reg   <= 1'b1;
            mosi_reg   <= 1'b0;
            sync_n_reg <= 1'b1;
        end else begin
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            sclk_reg   <= sclk_next;
            mosi_reg   <= mosi_next;
            sync_n_reg <= sync_n_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign sclk   = sclk_reg;
    assign mosi   = mosi_reg;
    assign sync_n = sync_n_reg;

endmodule

// File: tb/tb_nh7020_dac_frame_writer.sv
// Testbench for nh7020_dac_frame_writer.
// Two lanes run side by side: SCLK_DIV=4 and SCLK_DIV=1, both with GAP_CYCLES=8.
// Each lane has its own reference model, built from frame-length arithmetic:
// a frame occupies 50*DIV+GAP cycles, and strobes that arrive meanwhile
// overwrite a single pending slot. The model pushes the expected 24-bit frames
// into a queue. A separate monitor decodes the SPI pins and pops from the queue.
module tb_nh7020_dac_frame_writer;
    localparam int         GAP  = 8;
    localparam logic [3:0] CMD4 = 4'b0011;

    logic clk;
    int   checks;
    int   errors;
    int   n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int DIV = (gi == 0) ? 4 : 1;

        logic        reset;
        logic [15:0] dat;
        logic        dat_valid;
        logic        busy, done, sclk, mosi, sync_n;

        nh7020_dac_frame_writer #(
            .SCLK_DIV  (DIV),
            .GAP_CYCLES(GAP),
            .CMD       (CMD4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .dat      (dat),
            .dat_valid(dat_valid),
            .busy     (busy),
            .done     (done),
            .sclk     (sclk),
            .mosi     (mosi),
            .sync_n   (sync_n)
        );

        // ---------------- reference model ----------------
        logic [23:0] exp_q[$];
        int          edge_n;
        int          frame_end;
        logic        model_active;
        logic        pend_v;
        logic [15:0] pend_w;
`ifdef NH7020_DAC_SKIP_DUP_EN
        logic        last_v;
        logic [15:0] last_w;
`endif

        task automatic model_start(input logic [15:0] w);
`ifdef NH7020_DAC_SKIP_DUP_EN
            if (last_v && (w == last_w)) begin
                model_active = 1'b0;
                return;
            end
            last_v = 1'b1;
            last_w = w;
`endif
            exp_q.push_back({CMD4, w, 4'h0});
            model_active = 1'b1;
            frame_end    = edge_n + 50 * DIV + GAP;
        endtask

        // One clock edge as seen by the model
        task automatic model_step(input logic dv, input logic [15:0] d);
            edge_n++;
            if (model_active && (edge_n == frame_end)) begin
                if (dv)          model_start(d);
                else if (pend_v) model_start(pend_w);
                else             model_active = 1'b0;
                pend_v = 1'b0;
            end else if (model_active) begin
                if (dv) begin
                    pend_w = d;
                    pend_v = 1'b1;
                end
            end else if (dv) begin
                model_start(d);
            end
        endtask

        // ---------------- stimulus ----------------
        task automatic tick(input logic dv, input logic [15:0] d);
            dat_valid = dv;
            dat       = d;
            model_step(dv, d);
            @(negedge clk);
            checks++;
            if (busy !== model_active) begin
                errors++;
                $display("FAIL lane%0d busy at edge %0d: got %b expected %b", gi, edge_n, busy, model_active);
            end
        endtask

        task automatic apply_reset();
            dat_valid = 1'b0;
            reset     = 1'b1;
            #1;
            checks++;
            if (sync_n !== 1'b1 || sclk !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
                errors++;
                $display("FAIL lane%0d reset_pins: got sync_n=%b sclk=%b done=%b busy=%b mosi=%b expected 1 1 0 0 0",
                         gi, sync_n, sclk, done, busy, mosi);
            end
            model_active = 1'b0;
            pend_v       = 1'b0;
`ifdef NH7020_DAC_SKIP_DUP_EN
            last_v = 1'b0;
`endif
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
        endtask

        task automatic drain();
            for (int i = 0; i < 4000 && model_active; i++) tick(1'b0, 16'h0000);
            repeat (4) tick(1'b0, 16'h0000);
            checks++;
            if (model_active || exp_q.size() != 0) begin
                errors++;
                $display("FAIL lane%0d drain: got %0d frames outstanding, expected 0", gi, exp_q.size());
            end
        endtask

        initial begin
            logic [15:0] w;
            reset        = 1'b1;
            dat_valid    = 1'b0;
            dat          = 16'h0000;
            edge_n       = 0;
            frame_end    = 0;
            model_active = 1'b0;
            pend_v       = 1'b0;
            pend_w       = 16'h0000;
            @(negedge clk);
            apply_reset();

            // basic frame
            tick(1'b1, 16'hABCD);
            drain();

            // mid-frame strobes: latest pending wins
            tick(1'b1, 16'h0001);
            repeat (30 * DIV) tick(1'b0, 16'h0000);
            tick(1'b1, 16'h1111);
            repeat (5) tick(1'b0, 16'h0000);
            tick(1'b1, 16'h2222);
            drain();

            // reset around bit 10 aborts the frame; the next frame is clean
            tick(1'b1, 16'h5A5A);
            repeat (22 * DIV) tick(1'b0, 16'h0000);
            apply_reset();
            tick(1'b1, 16'hC3C3);
            drain();

            // strobe exactly on the last GAP cycle
            tick(1'b1, 16'h4444);
            for (int k = 0; k < 5000 && (edge_n + 1 != frame_end); k++) tick(1'b0, 16'h0000);
            tick(1'b1, 16'h5555);
            drain();

            // repeated words
            tick(1'b1, 16'h7FFF);
            drain();
            tick(1'b1, 16'h7FFF);
            drain();
            tick(1'b1, 16'h8000);
            drain();

            // extremes back to back
            tick(1'b1, 16'hFFFF);
            tick(1'b0, 16'h0000);
            tick(1'b1, 16'h0000);
            drain();

            // random traffic, with some repeated words
            w = 16'($urandom);
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 99) < 4) begin
                    if ($urandom_range(0, 3) != 0) w = 16'($urandom);
                    tick(1'b1, w);
                end else begin
                    tick(1'b0, 16'($urandom));
                end
            end
            drain();

            n_done++;
        end

        // ---------------- monitor ----------------
        initial begin
            logic        sync_prev, sclk_prev, in_frame, have_prev;
            int          low_len, run_len, high_len, bits;
            logic [23:0] frame;
            logic [23:0] exp;
            sync_prev = 1'b1;
            sclk_prev = 1'b1;
            in_frame  = 1'b0;
            have_prev = 1'b0;
            low_len   = 0;
            run_len   = 0;
            high_len  = 0;
            bits      = 0;
            frame     = '0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    in_frame  = 1'b0;
                    have_prev = 1'b0;
                    high_len  = 0;
                    sync_prev = 1'b1;
                    sclk_prev = 1'b1;
                end else begin
                    if (!sync_n && sync_prev) begin
                        if (have_prev) begin
                            checks++;
                            if (high_len < GAP) begin
                                errors++;
                                $display("FAIL lane%0d sync_gap: got %0d expected >= %0d", gi, high_len, GAP);
                            end
                        end
                        in_frame = 1'b1;
                        bits     = 0;
                        frame    = '0;
                        low_len  = 0;
                        run_len  = 0;
                    end
                    if (in_frame && !sync_n) begin
                        low_len++;
                        if (sclk != sclk_prev) begin
                            checks++;
                            if (run_len != DIV) begin
                                errors++;
                                $display("FAIL lane%0d sclk_half: got %0d expected %0d", gi, run_len, DIV);
                            end
                            if (!sclk) begin
                                frame = {frame[22:0], mosi};
                                bits++;
                            end
                            run_len = 1;
                        end else begin
                            run_len++;
                        end
                    end
                    if (sync_n && !sync_prev && in_frame) begin
                        in_frame = 1'b0;
                        checks++;
                        if (done !== 1'b1) begin
                            errors++;
                            $display("FAIL lane%0d done_pulse: got %b expected 1", gi, done);
                        end
                        checks++;
                        if (low_len != 50 * DIV) begin
                            errors++;
                            $display("FAIL lane%0d sync_low: got %0d expected %0d", gi, low_len, 50 * DIV);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL lane%0d frame: got %06h expected none", gi, frame);
                        end else begin
                            exp = exp_q.pop_front();
                            if (bits != 24 || frame !== exp) begin
                                errors++;
                                $display("FAIL lane%0d frame: got %06h (%0d bits) expected %06h (24 bits)",
                                         gi, frame, bits, exp);
                            end else begin
                                $display("lane%0d div=%0d frame %06h ok", gi, DIV, frame);
                            end
                        end
                        have_prev = 1'b1;
                        high_len  = 0;
                    end else begin
                        checks++;
                        if (done !== 1'b0) begin
                            errors++;
                            $display("FAIL lane%0d done_spurious: got %b expected 0", gi, done);
                        end
                    end
                    if (sync_n) high_len++;
                    sync_prev = sync_n;
                    sclk_prev = sclk;
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        n_done = 0;
        for (int i = 0; i < 60000 && n_done < 2; i++) @(posedge clk);
        if (n_done < 2) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d lanes finished expected 2", n_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
